// File: rtl/note_sequencer_pkg.sv
// Shared constants, song ROM entry layout and FSM state encoding for the note sequencer.
package note_sequencer_pkg;

    localparam logic [2:0] MODE_MANUAL = 3'b001;
    localparam logic [2:0] MODE_AUTO   = 3'b011;
    localparam logic [2:0] MODE_LEARN  = 3'b111;

    localparam logic [4:0] NOTE_SILENT = 5'd0;
    localparam logic [4:0] NOTE_MAX    = 5'd21;
    localparam logic [4:0] NOTE_END    = 5'd31;

    localparam int ENTRY_W  = 8;
    localparam int NOTE_MSB = 7;
    localparam int NOTE_LSB = 3;
    localparam int DUR_MSB  = 2;
    localparam int DUR_LSB  = 0;

    // state   | meaning
    // S_IDLE  | waiting for start in auto mode
    // S_FETCH | song ROM address presented, read in flight
    // S_LOAD  | ROM entry valid: end marker or note/duration latch
    // S_PLAY  | note sounding for dur+1 ticks
    // S_GAP   | silent ticks between notes
    // S_DONE  | one-cycle done pulse before returning to idle
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } seq_state_e;

    function automatic logic [ENTRY_W-1:0] rom_entry(input logic [4:0] note, input logic [2:0] dur);
        return {note, dur};
    endfunction

endpackage

// File: rtl/note_sequencer_song_rom.sv
// Song table: {song, addr} -> {note, dur} entry with a one-cycle registered read.
module note_sequencer_song_rom
    import note_sequencer_pkg::*;
#(
    parameter int ADDR_W = 6
) (
    input  logic                i_clk,
    input  logic [1:0]          i_song,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic [ENTRY_W-1:0]  o_entry
);

    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] r_entry;

    always_comb begin
        w_entry = rom_entry(NOTE_END, 3'd0);
        case (i_song)
            2'd0: begin
                case (i_addr)
                    ADDR_W'(0): w_entry = rom_entry(5'd8, 3'd1);
                    ADDR_W'(1): w_entry = rom_entry(5'd10, 3'd0);
                    default:    w_entry = rom_entry(NOTE_END, 3'd0);
                endcase
            end
            2'd1: begin
                case (i_addr)
                    ADDR_W'(0): w_entry = rom_entry(5'd1, 3'd0);
                    ADDR_W'(1): w_entry = rom_entry(5'd5, 3'd1);
                    ADDR_W'(2): w_entry = rom_entry(5'd8, 3'd2);
                    default:    w_entry = rom_entry(NOTE_END, 3'd0);
                endcase
            end
            2'd2: begin
                case (i_addr)
                    ADDR_W'(0): w_entry = rom_entry(5'd15, 3'd7);
                    default:    w_entry = rom_entry(NOTE_END, 3'd0);
                endcase
            end
            // Song 3 never hits the end marker, so it ends by address wrap.
            default: w_entry = rom_entry(5'd1, 3'd0);
        endcase
    end

    always_ff @(posedge i_clk) begin
        r_entry <= w_entry;
    end

    assign o_entry = r_entry;

endmodule

// File: rtl/note_sequencer.sv
// Auto-play song sequencer and buzzer note mux (auto / manual / silent).
// SONG_LOOP_EN: when defined, a natural song end restarts the song instead of returning to idle.
module note_sequencer
    import note_sequencer_pkg::*;
#(
    parameter int TICK_CYCLES = 6_250_000,
    parameter int GAP_TICKS   = 1,
    parameter int ADDR_W      = 6
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [2:0]  i_mode,
    input  logic [4:0]  i_manual_note,
    input  logic [1:0]  i_song_sel,
    input  logic        i_start,
    input  logic        i_pause,
    output logic [4:0]  o_note,
    output logic        o_busy,
    output logic        o_done
);

    localparam int            TW        = $clog2(TICK_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

    seq_state_e          r_state, w_state_nxt;
    logic [1:0]          r_song, w_song_nxt;
    logic [ADDR_W-1:0]   r_addr, w_addr_nxt;
    logic [4:0]          r_play_note, w_play_note_nxt;
    logic [3:0]          r_remain, w_remain_nxt;
    logic [7:0]          r_gap_cnt, w_gap_nxt;
    logic [TW-1:0]       r_tick_cnt, w_tick_nxt;
    logic [4:0]          r_note;
    logic                r_done;

    logic [ENTRY_W-1:0]  w_rom_entry;
    logic                w_run;
    logic                w_tick;
    logic                w_advance;
    logic                w_end_evt;
    logic                w_done_nxt;

    note_sequencer_song_rom #(.ADDR_W(ADDR_W)) u_song_rom (
        .i_clk   (i_clk),
        .i_song  (r_song),
        .i_addr  (r_addr),
        .o_entry (w_rom_entry)
    );

    assign w_run  = ((r_state == S_PLAY) || (r_state == S_GAP)) && !i_pause;
    assign w_tick = w_run && (r_tick_cnt == TICK_LAST);

    always_comb begin
        w_state_nxt     = r_state;
        w_song_nxt      = r_song;
        w_addr_nxt      = r_addr;
        w_play_note_nxt = r_play_note;
        w_remain_nxt    = r_remain;
        w_gap_nxt       = r_gap_cnt;
        w_tick_nxt      = r_tick_cnt;
        w_advance       = 1'b0;
        w_end_evt       = 1'b0;

        if (w_run) begin
            w_tick_nxt = w_tick ? '0 : r_tick_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                if (i_start && (i_mode == MODE_AUTO)) begin
                    w_song_nxt  = i_song_sel;
                    w_addr_nxt  = '0;
                    w_state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (!i_pause) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!i_pause) begin
                    if (w_rom_entry[NOTE_MSB:NOTE_LSB] == NOTE_END) begin
                        w_end_evt = 1'b1;
                    end else begin
                        w_play_note_nxt = w_rom_entry[NOTE_MSB:NOTE_LSB];
                        w_remain_nxt    = {1'b0, w_rom_entry[DUR_MSB:DUR_LSB]} + 4'd1;
                        w_tick_nxt      = '0;
                        w_state_nxt     = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                if (w_tick) begin
                    w_remain_nxt = r_remain - 4'd1;
                    if (r_remain == 4'd1) begin
                        if (GAP_TICKS > 0) begin
                            w_gap_nxt   = GAP_TICKS[7:0];
                            w_state_nxt = S_GAP;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end
                end
            end
            S_GAP: begin
                if (w_tick) begin
                    w_gap_nxt = r_gap_cnt - 8'd1;
                    if (r_gap_cnt == 8'd1) begin
                        w_advance = 1'b1;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_advance) begin
            if (r_addr == '1) begin
                w_end_evt = 1'b1;
            end else begin
                w_addr_nxt  = r_addr + 1'b1;
                w_state_nxt = S_FETCH;
            end
        end

        if (w_end_evt) begin
`ifdef SONG_LOOP_EN
            w_addr_nxt  = '0;
            w_state_nxt = S_FETCH;
`else
            w_state_nxt = S_DONE;
`endif
        end

        // Leaving auto mode cancels playback outright; a coincident song end gives no done.
        if ((r_state != S_IDLE) && (i_mode != MODE_AUTO)) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign w_done_nxt = w_end_evt && (i_mode == MODE_AUTO);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_song      <= 2'd0;
            r_addr      <= '0;
            r_play_note <= NOTE_SILENT;
            r_remain    <= 4'd0;
            r_gap_cnt   <= 8'd0;
            r_tick_cnt  <= '0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_song      <= w_song_nxt;
            r_addr      <= w_addr_nxt;
            r_play_note <= w_play_note_nxt;
            r_remain    <= w_remain_nxt;
            r_gap_cnt   <= w_gap_nxt;
            r_tick_cnt  <= w_tick_nxt;
            r_done      <= w_done_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_note <= NOTE_SILENT;
        end else begin
            case (i_mode)
                MODE_MANUAL: r_note <= (i_manual_note > NOTE_MAX) ? NOTE_SILENT : i_manual_note;
                MODE_AUTO:   r_note <= ((r_state == S_PLAY) && !i_pause) ? r_play_note : NOTE_SILENT;
                MODE_LEARN:  r_note <= NOTE_SILENT;
                default:     r_note <= NOTE_SILENT;
            endcase
        end
    end

    assign o_note = r_note;
    assign o_busy = (r_state != S_IDLE);
    assign o_done = r_done;

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with TICK_CYCLES=4, GAP_TICKS=1 and the built-in song table.
module tb_note_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] mode;
    logic [4:0] manual_note;
    logic [1:0] song_sel;
    logic       start;
    logic       pause;
    logic [4:0] note;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    note_sequencer #(.TICK_CYCLES(4), .GAP_TICKS(1), .ADDR_W(6)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_mode        (mode),
        .i_manual_note (manual_note),
        .i_song_sel    (song_sel),
        .i_start       (start),
        .i_pause       (pause),
        .o_note        (note),
        .o_busy        (busy),
        .o_done        (done)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // Song 0 note seen k cycles after the start was sampled:
    // FETCH/LOAD (2), C4 (8), GAP+FETCH+LOAD (6), E4 (4), GAP+FETCH+LOAD (6).
    function automatic int song0_note(input int k);
        if (k <= 2)  return 0;
        if (k <= 10) return 8;
        if (k <= 16) return 0;
        if (k <= 20) return 10;
        return 0;
    endfunction

    task automatic start_song(input logic [1:0] s);
        mode     = 3'b011;
        song_sel = s;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic go_idle();
        mode        = 3'b001;
        manual_note = 5'd0;
        pause       = 1'b0;
        step(2);
        mode = 3'b011;
        step();
    endtask

    task automatic run_song0(input string tag, input bit poke);
        start_song(2'd0);
        check_val({tag, "_busy_start"}, int'(busy), 1);
        for (int k = 1; k <= 26; k++) begin
            step();
            check_val($sformatf("%s_note_k%0d", tag, k), int'(note), song0_note(k));
            check_val($sformatf("%s_done_k%0d", tag, k), int'(done), (k == 26) ? 1 : 0);
            if (poke && k == 5) begin
                start    = 1'b1;
                song_sel = 2'd2;
            end
            if (poke && k == 6) begin
                start    = 1'b0;
                song_sel = 2'd0;
            end
        end
        check_val({tag, "_busy_k26"}, int'(busy), 1);
        step();
`ifdef SONG_LOOP_EN
        check_val({tag, "_busy_k27"}, int'(busy), 1);
`else
        check_val({tag, "_busy_k27"}, int'(busy), 0);
`endif
        check_val({tag, "_done_k27"}, int'(done), 0);
    endtask

    initial begin : main
        int cnt_a;
        int cnt_b;
        int done_at;
        int prev;
        bit seen;

        rst = 1'b1; mode = 3'b000; manual_note = 5'd0; song_sel = 2'd0; start = 1'b0; pause = 1'b0;
        step(3);
        rst = 1'b0;
        step();
        check_val("rst_note", int'(note), 0);
        check_val("rst_busy", int'(busy), 0);
        check_val("rst_done", int'(done), 0);

        // Manual mode mux and range clamp
        mode = 3'b001; manual_note = 5'd10; step();
        check_val("man_10", int'(note), 10);
        manual_note = 5'd25; step();
        check_val("man_25", int'(note), 0);
        manual_note = 5'd21; step();
        check_val("man_21", int'(note), 21);
        manual_note = 5'd22; step();
        check_val("man_22", int'(note), 0);
        mode = 3'b111; manual_note = 5'd10; step();
        check_val("learn_note", int'(note), 0);

        // Start outside auto mode is ignored
        mode = 3'b001; start = 1'b1; step(); start = 1'b0; step(3);
        check_val("start_man_busy", int'(busy), 0);
        mode = 3'b111; start = 1'b1; step(); start = 1'b0; step(3);
        check_val("start_learn_busy", int'(busy), 0);
        go_idle();
        check_val("auto_idle_note", int'(note), 0);

        // Plain playback of song 0
        run_song0("s0", 1'b0);
        go_idle();

        // Start while busy must not restart or switch song
        run_song0("s0poke", 1'b1);
        go_idle();

        // Pause for 3 clocks inside C4
        start_song(2'd0);
        cnt_a = 0; cnt_b = 0; done_at = -1;
        for (int k = 1; k <= 60 && done_at < 0; k++) begin
            pause = (k >= 5 && k <= 7);
            step();
            if (note == 5'd8)  cnt_a++;
            if (note == 5'd10) cnt_b++;
            if (k == 6) check_val("pause_note", int'(note), 0);
            if (done) done_at = k;
        end
        pause = 1'b0;
        check_val("pause_c4_len", cnt_a, 8);
        check_val("pause_e4_len", cnt_b, 4);
        check_val("pause_done_at", done_at, 29);
        go_idle();

        // Leave auto mode mid-song
        start_song(2'd0);
        step(5);
        mode = 3'b001; manual_note = 5'd5;
        step();
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_note", int'(note), 5);
        cnt_a = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) cnt_a++;
        end
        check_val("abort_no_done", cnt_a, 0);
        mode = 3'b011; manual_note = 5'd0; step(3);
        check_val("abort_stay_idle", int'(busy), 0);

        // Synchronous reset mid-play
        start_song(2'd0);
        step(4);
        rst = 1'b1;
        step();
        check_val("midrst_note", int'(note), 0);
        check_val("midrst_busy", int'(busy), 0);
        check_val("midrst_done", int'(done), 0);
        rst = 1'b0;
        cnt_a = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (done) cnt_a++;
        end
        check_val("midrst_no_done", cnt_a, 0);
        go_idle();

        // Longest duration (dur=7 -> 8 ticks = 32 clocks)
        start_song(2'd2);
        cnt_a = 0; seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            step();
            if (note == 5'd15) cnt_a++;
            if (done) seen = 1'b1;
        end
        check_val("dur7_len", cnt_a, 32);
        check_val("dur7_done", int'(seen), 1);
        go_idle();

        // Song without end marker ends after the last address
        start_song(2'd3);
        cnt_a = 0; seen = 1'b0; prev = 0;
        for (int k = 0; k < 1000 && !seen; k++) begin
            step();
            if (note == 5'd1 && prev != 1) cnt_a++;
            prev = int'(note);
            if (done) seen = 1'b1;
        end
        check_val("wrap_notes", cnt_a, 64);
        check_val("wrap_done", int'(seen), 1);
        go_idle();

        // Start accepted while paused; playback waits for pause release
        pause = 1'b1;
        start_song(2'd1);
        check_val("pstart_busy", int'(busy), 1);
        step(10);
        check_val("pstart_held_busy", int'(busy), 1);
        check_val("pstart_held_note", int'(note), 0);
        pause = 1'b0;
        seen = 1'b0; cnt_a = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            step();
            if (note == 5'd5) cnt_a++;
            if (done) seen = 1'b1;
        end
        check_val("pstart_g3_len", cnt_a, 8);
        check_val("pstart_done", int'(seen), 1);
        go_idle();

`ifdef SONG_LOOP_EN
        start_song(2'd0);
        cnt_a = 0; done_at = -1; cnt_b = -1;
        for (int k = 1; k <= 120 && cnt_a < 2; k++) begin
            step();
            if (done) begin
                cnt_a++;
                if (cnt_a == 1) done_at = k; else cnt_b = k - done_at;
            end
        end
        check_val("loop_two_dones", cnt_a, 2);
        check_val("loop_period", cnt_b, 26);
        check_val("loop_busy", int'(busy), 1);
        step(3);
        check_val("loop_replay_c4", int'(note), 8);
        rst = 1'b1;
        step();
        check_val("loop_rst_note", int'(note), 0);
        check_val("loop_rst_busy", int'(busy), 0);
        rst = 1'b0;
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
